noc_ni_tx: RTL and testbench

//  Network-interface injection stage, one per tile, feeding the router's local (R, index 4) input port.

---
 rtl/router_pkg.sv | 49 ++++
 rtl/noc_credit_cnt.sv | 24 ++
 rtl/noc_ni_tx.sv | 134 +++++++++++++
 tb/tb_noc_ni_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared NoC router types: flit status, flit type encoding, channel layout and head-flit field packing.
package router_pkg;
  localparam int NUM_VCS        = 2;
  localparam int VC_BITS        = $clog2(NUM_VCS);
  localparam int DIM_BITS       = 2;
  localparam int NOC_LINK_W     = 32;
  localparam int MAX_BODY_FLITS = 15;
  localparam int LEN_BITS       = $clog2(MAX_BODY_FLITS + 1);

  localparam int HD_DST_Y = 0;
  localparam int HD_DST_X = DIM_BITS;
  localparam int HD_SRC_Y = 2 * DIM_BITS;
  localparam int HD_SRC_X = 3 * DIM_BITS;
  localparam int HD_LEN   = 4 * DIM_BITS;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } ftype_e;

  typedef struct packed {
    logic               valid;
    logic [VC_BITS-1:0] vc;
    ftype_e             ftype;
  } flit_status_t;

  typedef struct packed {
    flit_status_t          status;
    logic [NOC_LINK_W-1:0] data;
  } channel_t;

  localparam int CH_BITS = $bits(channel_t);

  function automatic logic [NOC_LINK_W-1:0] head_data(
    input logic [DIM_BITS-1:0] dx, dy, sx, sy,
    input logic [LEN_BITS-1:0] len
  );
    logic [NOC_LINK_W-1:0] d;
    d = '0;
    d[HD_DST_Y +: DIM_BITS] = dy;
    d[HD_DST_X +: DIM_BITS] = dx;
    d[HD_SRC_Y +: DIM_BITS] = sy;
    d[HD_SRC_X +: DIM_BITS] = sx;
    d[HD_LEN   +: LEN_BITS] = len;
    return d;
  endfunction
endpackage

// File: rtl/noc_credit_cnt.sv
// Per-VC downstream credit counter: starts full, -1 per flit sent, +1 per returned slot.
module noc_credit_cnt #(
  parameter  int BUF_DEPTH = 4,
  localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)              r_cnt <= CW'(BUF_DEPTH);
    else if (i_inc && !i_dec) r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc) r_cnt <= r_cnt - 1'b1;
  end

  // An underflow also wraps above BUF_DEPTH, so this one check covers both directions.
  a_cnt_range: assert property (@(posedge clk) disable iff (!arst_n) r_cnt <= CW'(BUF_DEPTH));

  assign o_cnt = r_cnt;
endmodule

// File: rtl/noc_ni_tx.sv
// NI injection stage: segments descriptors + payload into head/body/tail flits, round-robin VC
// select with per-VC credits. Optional NI_TX_STATS_EN adds flit and stall counters.
module noc_ni_tx
  import router_pkg::*;
#(
  parameter  int BUF_DEPTH = 4,
  localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DIM_BITS-1:0]   my_x,
  input  logic [DIM_BITS-1:0]   my_y,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [DIM_BITS-1:0]   pkt_dst_x,
  input  logic [DIM_BITS-1:0]   pkt_dst_y,
  input  logic [LEN_BITS-1:0]   pkt_len,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  input  logic [NOC_LINK_W-1:0] pld_data,
  output channel_t              out_flit,
  input  logic [NUM_VCS-1:0]    in_credit
`ifdef NI_TX_STATS_EN
  ,
  output logic [31:0]           stat_flits,
  output logic [31:0]           stat_stalls
`endif
);
  typedef enum logic {ST_IDLE, ST_BODY} state_e;

  state_e                r_state;
  logic                  r_live;
  logic [VC_BITS-1:0]    r_rr, r_vc;
  logic [LEN_BITS-1:0]   r_len, r_cnt;
  channel_t              r_out;

  logic [NUM_VCS-1:0][CW-1:0] w_cred;
  logic [NUM_VCS-1:0]    w_nz;
  logic [VC_BITS-1:0]    w_sel, w_send_vc;
  logic                  w_pkt_acc, w_pld_acc, w_send, w_last;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_cred
    noc_credit_cnt #(.BUF_DEPTH(BUF_DEPTH)) u_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .i_inc  (in_credit[v]),
      .i_dec  (w_send && (w_send_vc == VC_BITS'(v))),
      .o_cnt  (w_cred[v])
    );
    assign w_nz[v] = |w_cred[v];
  end

  // First VC with credit, scanning upward from the round-robin pointer.
  always_comb begin
    logic               found;
    logic [VC_BITS-1:0] idx;
    w_sel = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      idx = VC_BITS'((int'(r_rr) + i) % NUM_VCS);
      if (!found && w_nz[idx]) begin
        w_sel = idx;
        found = 1'b1;
      end
    end
  end

  // r_live keeps pkt_ready low while reset is held and for the first edge after it.
  assign pkt_ready = r_live && (r_state == ST_IDLE) && (|w_nz);
  assign pld_ready = (r_state == ST_BODY) && w_nz[r_vc];
  assign w_pkt_acc = pkt_valid && pkt_ready;
  assign w_pld_acc = pld_valid && pld_ready;
  assign w_send    = w_pkt_acc || w_pld_acc;
  assign w_send_vc = w_pkt_acc ? w_sel : r_vc;
  assign w_last    = (r_cnt + 1'b1) == r_len;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_rr    <= '0;
      r_vc    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_live             <= 1'b1;
      r_out.status.valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_pkt_acc) begin
          r_rr         <= VC_BITS'((int'(w_sel) + 1) % NUM_VCS);
          r_vc         <= w_sel;
          r_len        <= pkt_len;
          r_cnt        <= '0;
          r_out.status <= '{valid: 1'b1, vc: w_sel,
                            ftype: (pkt_len == '0) ? FT_HEADTAIL : FT_HEAD};
          r_out.data   <= head_data(pkt_dst_x, pkt_dst_y, my_x, my_y, pkt_len);
          r_state      <= (pkt_len == '0) ? ST_IDLE : ST_BODY;
        end
        ST_BODY: if (w_pld_acc) begin
          r_cnt        <= r_cnt + 1'b1;
          r_out.status <= '{valid: 1'b1, vc: r_vc, ftype: w_last ? FT_TAIL : FT_BODY};
          r_out.data   <= pld_data;
          if (w_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_flit = r_out;

`ifdef NI_TX_STATS_EN
  logic [31:0] r_flits, r_stalls;
  logic        w_stall;

  assign w_stall = (r_live && (r_state == ST_IDLE) && pkt_valid && !(|w_nz)) ||
                   ((r_state == ST_BODY) && pld_valid && !w_nz[r_vc]);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_flits  <= '0;
      r_stalls <= '0;
    end else begin
      if (w_send)  r_flits  <= r_flits + 1'b1;
      if (w_stall) r_stalls <= r_stalls + 1'b1;
    end
  end

  assign stat_flits  = r_flits;
  assign stat_stalls = r_stalls;
`endif
endmodule

// File: tb/tb_noc_ni_tx.sv
// Bench for noc_ni_tx: packet-level model checked every cycle plus directed literal checks.
module tb_noc_ni_tx;
  import router_pkg::*;

  logic                  clk = 1'b0;
  logic                  arst_n = 1'b0;
  logic [DIM_BITS-1:0]   my_x = '0, my_y = '0;
  logic                  pkt_valid = 1'b0, pkt_ready;
  logic [DIM_BITS-1:0]   pkt_dst_x = '0, pkt_dst_y = '0;
  logic [LEN_BITS-1:0]   pkt_len = '0;
  logic                  pld_valid = 1'b0, pld_ready;
  logic [NOC_LINK_W-1:0] pld_data = '0;
  channel_t              out_flit;
  logic [NUM_VCS-1:0]    in_credit = '0;
`ifdef NI_TX_STATS_EN
  logic [31:0]           stat_flits, stat_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_ni_tx #(.BUF_DEPTH(4)) dut (
    .clk(clk), .arst_n(arst_n), .my_x(my_x), .my_y(my_y),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dst_x(pkt_dst_x), .pkt_dst_y(pkt_dst_y), .pkt_len(pkt_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .out_flit(out_flit), .in_credit(in_credit)
`ifdef NI_TX_STATS_EN
    , .stat_flits(stat_flits), .stat_stalls(stat_stalls)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  bit          m_live, m_idle;
  int          m_cred[NUM_VCS];
  int          m_rr, m_cur, m_len, m_cnt;
  bit          e_valid;
  int          e_vc, e_ft;
  logic [31:0] e_data;
  int unsigned m_flits, m_stalls;

  function automatic bit m_pkt_rdy();
    bit any = 0;
    for (int v = 0; v < NUM_VCS; v++) if (m_cred[v] > 0) any = 1;
    return m_live && m_idle && any;
  endfunction

  function automatic bit m_pld_rdy();
    return !m_idle && (m_cred[m_cur] > 0);
  endfunction

  always @(posedge clk or negedge arst_n) begin : model
    bit prdy, lrdy, snd;
    int sv, c;
    if (!arst_n) begin
      m_live = 0; m_idle = 1; m_rr = 0; m_cur = 0; m_len = 0; m_cnt = 0;
      for (int v = 0; v < NUM_VCS; v++) m_cred[v] = 4;
      e_valid = 0; e_vc = 0; e_ft = 0; e_data = '0;
      m_flits = 0; m_stalls = 0;
    end else begin
      prdy = m_pkt_rdy();
      lrdy = m_pld_rdy();
      snd = 0;
      sv = -1;
      e_valid = 0;
      if ((m_live && m_idle && pkt_valid && !prdy) || (!m_idle && pld_valid && !lrdy))
        m_stalls++;
      if (m_idle && pkt_valid && prdy) begin
        for (int i = 0; i < NUM_VCS; i++) begin
          c = (m_rr + i) % NUM_VCS;
          if (sv < 0 && m_cred[c] > 0) sv = c;
        end
        m_rr = (sv + 1) % NUM_VCS;
        snd = 1;
        e_vc = sv;
        e_ft = (pkt_len == 0) ? 3 : 1;
        e_data = pkt_dst_y + 4 * pkt_dst_x + 16 * my_y + 64 * my_x + 256 * pkt_len;
        if (pkt_len != 0) begin
          m_idle = 0; m_cur = sv; m_len = pkt_len; m_cnt = 0;
        end
      end else if (!m_idle && pld_valid && lrdy) begin
        m_cnt++;
        snd = 1;
        e_vc = m_cur;
        e_ft = (m_cnt == m_len) ? 2 : 0;
        e_data = pld_data;
        if (m_cnt == m_len) m_idle = 1;
      end
      if (snd) begin
        e_valid = 1;
        m_flits++;
      end
      for (int v = 0; v < NUM_VCS; v++)
        m_cred[v] += int'(in_credit[v]) - ((snd && e_vc == v) ? 1 : 0);
      m_live = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("out_valid", out_flit.status.valid, e_valid);
    chk("out_data", out_flit.data, e_data);
    if (e_valid) begin
      chk("out_vc", out_flit.status.vc, e_vc);
      chk("out_ftype", out_flit.status.ftype, e_ft);
    end
    chk("pkt_ready", pkt_ready, m_pkt_rdy());
    chk("pld_ready", pld_ready, m_pld_rdy());
    for (int v = 0; v < NUM_VCS; v++) begin
      chk("credit", dut.w_cred[v], m_cred[v]);
      if (m_cred[v] > 4 || m_cred[v] < 0) chk("model_credit_range", m_cred[v], 4);
    end
`ifdef NI_TX_STATS_EN
    chk("stat_flits", stat_flits, m_flits);
    chk("stat_stalls", stat_stalls, m_stalls);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    pkt_valid = 1'b0; pld_valid = 1'b0; in_credit = '0;
    tick(); tick();
    arst_n = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input int dx, input int dy, input int ln);
    bit ok = 0;
    pkt_valid = 1'b1;
    pkt_dst_x = DIM_BITS'(dx); pkt_dst_y = DIM_BITS'(dy); pkt_len = LEN_BITS'(ln);
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (pkt_ready) ok = 1;
      tick();
    end
    pkt_valid = 1'b0;
    chk("pkt_handshake", ok, 1);
  endtask

  task automatic send_pld(input logic [31:0] d);
    bit ok = 0;
    pld_valid = 1'b1;
    pld_data = d;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (pld_ready) ok = 1;
      tick();
    end
    pld_valid = 1'b0;
    chk("pld_handshake", ok, 1);
  endtask

  task automatic chk_flit(input string nm, input int vc, input int ft, input logic [31:0] d);
    chk({nm, "_valid"}, out_flit.status.valid, 1);
    chk({nm, "_vc"}, out_flit.status.vc, vc);
    chk({nm, "_ftype"}, out_flit.status.ftype, ft);
    chk({nm, "_data"}, out_flit.data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    chk("rst_valid", out_flit.status.valid, 0);
    chk("rst_data", out_flit.data, 0);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_pld_ready", pld_ready, 0);
    do_reset();

    // 1: single-flit packet to (2,1) from (0,0)
    send_pkt(2, 1, 0);
    chk_flit("t1", 0, 3, 32'd9);

    // 2: len=3, payload every cycle, lands on vc1 (round-robin moved past vc0)
    send_pkt(1, 1, 3);
    chk_flit("t2_head", 1, 1, 32'h305);
    send_pld(32'hA);
    chk_flit("t2_a", 1, 0, 32'hA);
    send_pld(32'hB);
    chk_flit("t2_b", 1, 0, 32'hB);
    send_pld(32'hC);
    chk_flit("t2_c", 1, 2, 32'hC);

    // 3: exhaust all credits, then one returned slot admits exactly one flit
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_pkt(1, 0, 0);
      chk_flit("t3_fill", i % 2, 3, 32'd4);
    end
    pkt_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("t3_blocked", pkt_ready, 0);
      tick();
    end
    in_credit = 2'b10;
    tick();
    in_credit = '0;
    @(negedge clk); chk("t3_ready", pkt_ready, 1);
    tick();
    chk_flit("t3_one", 1, 3, 32'd4);
    @(negedge clk); chk("t3_reblocked", pkt_ready, 0);
    tick();
    chk("t3_no_second", out_flit.status.valid, 0);
    pkt_valid = 1'b0;

    // 4: body stalls on vc1 with zero credit, resumes after a credit pulse
    do_reset();
    send_pkt(0, 1, 0);
    send_pkt(1, 0, 5);
    chk_flit("t4_head", 1, 1, 32'h504);
    send_pld(32'h11); send_pld(32'h22); send_pld(32'h33);
    pld_valid = 1'b1; pld_data = 32'h44;
    repeat (2) begin
      @(negedge clk); chk("t4_blocked", pld_ready, 0);
      tick();
    end
    chk("t4_idle_out", out_flit.status.valid, 0);
    in_credit = 2'b10;
    tick();
    in_credit = '0;
    @(negedge clk); chk("t4_ready", pld_ready, 1);
    tick();
    pld_valid = 1'b0;
    chk_flit("t4_w4", 1, 0, 32'h44);
    in_credit = 2'b10;
    tick();
    in_credit = '0;
    send_pld(32'h55);
    chk_flit("t4_tail", 1, 2, 32'h55);

    // 5: send and credit return on the same VC in the same cycle
    do_reset();
    send_pkt(3, 3, 2);
    chk("t5_cred_head", dut.w_cred[0], 3);
    in_credit = 2'b01;
    send_pld(32'h77);
    in_credit = '0;
    chk("t5_cred_same", dut.w_cred[0], 3);
    send_pld(32'h88);
    chk_flit("t5_tail", 0, 2, 32'h88);
    chk("t5_cred_after", dut.w_cred[0], 2);
    chk("t5_cred_vc1", dut.w_cred[1], 4);

    // 6: reset mid-body aborts the packet; next packet restarts on vc0
    do_reset();
    send_pkt(1, 1, 0);
    send_pkt(3, 2, 5);
    send_pld(32'h1); send_pld(32'h2);
    arst_n = 1'b0;
    #1;
    chk("t6_valid", out_flit.status.valid, 0);
    chk("t6_data", out_flit.data, 0);
    chk("t6_cred0", dut.w_cred[0], 4);
    chk("t6_cred1", dut.w_cred[1], 4);
    chk("t6_pkt_ready", pkt_ready, 0);
    my_x = 2'd1; my_y = 2'd2;
    tick(); tick();
    arst_n = 1'b1;
    tick();
    send_pkt(3, 2, 1);
    chk_flit("t6_head", 0, 1, 32'd366);
    send_pld(32'hBEEF);
    chk_flit("t6_tail", 0, 2, 32'hBEEF);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
